// File: rtl/complex_acc_dump_35.sv
// Integrate-and-dump for complex products: accumulates a window of
// valid samples, then rounds, shifts and saturates to OW-bit I/Q.
module complex_acc_dump_35 #(
  parameter int IW = 35,
  parameter int AW = 43,
  parameter int OW = 18,
  parameter int SH = 17
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [7:0]    i_len,
  input  logic          i_vld,
  input  logic [IW-1:0] i_pr,
  input  logic [IW-1:0] i_pi,
  output logic          o_busy,
  output logic          o_vld,
  output logic [OW-1:0] o_qr,
  output logic [OW-1:0] o_qi,
  output logic          o_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DUMP = 2'd2;

  localparam int RS = (SH > 0) ? SH - 1 : 0;
  localparam logic signed [AW:0] RND =
    (SH > 0) ? ((AW+1)'(1) << RS) : '0;
  localparam logic signed [AW:0] MAXV =
    (AW+1)'(2**(OW-1) - 1);
  localparam logic signed [AW:0] MINV = ~MAXV;

  logic [1:0] state;
  logic [8:0] len;
  logic [8:0] cnt;
  logic [8:0] nlen;
  logic signed [AW-1:0] acc_r;
  logic signed [AW-1:0] acc_i;
  logic signed [AW-1:0] pr_x;
  logic signed [AW-1:0] pi_x;
  logic [OW:0] qr_n;
  logic [OW:0] qi_n;

  // One extra bit so the rounding add cannot wrap; MSB of result = sat
  function automatic logic [OW:0] quant(
    input logic signed [AW-1:0] a
  );
    logic signed [AW:0] t;
    logic [OW-1:0] q;
    logic sat;
    t = ($signed({a[AW-1], a}) + RND) >>> SH;
    sat = 1'b1;
    if (t > MAXV) begin
      q = MAXV[OW-1:0];
    end else if (t < MINV) begin
      q = MINV[OW-1:0];
    end else begin
      sat = 1'b0;
      q = t[OW-1:0];
    end
    return {sat, q};
  endfunction

  assign nlen = (i_len == 8'd0) ? 9'd256 : {1'b0, i_len};
  assign pr_x = $signed({{(AW-IW){i_pr[IW-1]}}, i_pr});
  assign pi_x = $signed({{(AW-IW){i_pi[IW-1]}}, i_pi});
  assign qr_n = quant(acc_r);
  assign qi_n = quant(acc_i);
  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      len   <= '0;
      cnt   <= '0;
      acc_r <= '0;
      acc_i <= '0;
      o_vld <= 1'b0;
      o_qr  <= '0;
      o_qi  <= '0;
      o_ovf <= 1'b0;
    end else begin
      o_vld <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (i_start) begin
            len   <= nlen;
            cnt   <= '0;
            state <= S_ACC;
          end
        end
        (state == S_ACC): begin
          if (i_vld) begin
            // first sample loads so no residue survives between windows
            acc_r <= (cnt == 9'd0) ? pr_x : acc_r + pr_x;
            acc_i <= (cnt == 9'd0) ? pi_x : acc_i + pi_x;
            cnt   <= cnt + 9'd1;
            if (cnt == len - 9'd1)
              state <= S_DUMP;
          end
        end
        (state == S_DUMP): begin
          o_vld <= 1'b1;
          o_qr  <= qr_n[OW-1:0];
          o_qi  <= qi_n[OW-1:0];
          o_ovf <= qr_n[OW] | qi_n[OW];
          if (i_start) begin
            len   <= nlen;
            cnt   <= '0;
            state <= S_ACC;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_acc_dump_35.sv
// Directed bench for complex_acc_dump_35 with SH=0, SH=2 and SH=17
// instances sharing one stimulus stream.
module tb_complex_acc_dump_35;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [7:0] i_len = '0;
  logic i_vld = 1'b0;
  logic [34:0] i_pr = '0;
  logic [34:0] i_pi = '0;

  logic b0, v0, f0, b2, v2, f2, b17, v17, f17;
  logic [17:0] r0, q0, r2, q2, r17, q17;

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  complex_acc_dump_35 #(.SH(0)) u0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_len(i_len), .i_vld(i_vld), .i_pr(i_pr), .i_pi(i_pi),
    .o_busy(b0), .o_vld(v0), .o_qr(r0), .o_qi(q0), .o_ovf(f0)
  );

  complex_acc_dump_35 #(.SH(2)) u2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_len(i_len), .i_vld(i_vld), .i_pr(i_pr), .i_pi(i_pi),
    .o_busy(b2), .o_vld(v2), .o_qr(r2), .o_qi(q2), .o_ovf(f2)
  );

  complex_acc_dump_35 u17 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
    .i_len(i_len), .i_vld(i_vld), .i_pr(i_pr), .i_pi(i_pi),
    .o_busy(b17), .o_vld(v17), .o_qr(r17), .o_qi(q17),
    .o_ovf(f17)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(
    input string tag,
    input logic signed [63:0] obs,
    input logic signed [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic samp(input int pr, input int pi);
    i_vld = 1'b1;
    i_pr = 35'($signed(pr));
    i_pi = 35'($signed(pi));
  endtask

  task automatic arm(input logic [7:0] len);
    i_start = 1'b1;
    i_len = len;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_busy", b2, 0);
    chk("rst_vld", v2, 0);
    chk("rst_qr", $signed(r2), 0);
    chk("rst_ovf", f2, 0);
    #10 i_rst_n = 1'b1;
    tick();

    // SH=2: four samples of 25 -> 100 -> 25
    arm(8'd4);
    chk("t1_busy", b2, 1);
    samp(25, 25);
    repeat (4) tick();
    i_vld = 1'b0;
    chk("t1_vld_early", v2, 0);
    tick();
    chk("t1_vld", v2, 1);
    chk("t1_qr", $signed(r2), 25);
    chk("t1_qi", $signed(q2), 25);
    chk("t1_ovf", f2, 0);
    chk("t1_busy_idle", b2, 0);
    tick();
    chk("t1_vld_one", v2, 0);
    chk("t1_hold", $signed(r2), 25);

    // SH=2 rounding: 6 -> 2, -6 -> -1
    arm(8'd2);
    samp(3, -3);
    repeat (2) tick();
    i_vld = 1'b0;
    tick();
    chk("t2_vld", v2, 1);
    chk("t2_qr", $signed(r2), 2);
    chk("t2_qi", $signed(q2), -1);
    chk("t2_ovf", f2, 0);

    // SH=17 saturation over 256 samples
    arm(8'd0);
    i_vld = 1'b1;
    i_pr = 35'h3_FFFF_FFFF;
    i_pi = 35'h4_0000_0000;
    repeat (255) tick();
    chk("t3_not_yet", v17, 0);
    tick();
    i_vld = 1'b0;
    chk("t3_vld_early", v17, 0);
    tick();
    chk("t3_vld", v17, 1);
    chk("t3_qr", $signed(r17), 131071);
    chk("t3_qi", $signed(q17), -131072);
    chk("t3_ovf", f17, 1);

    // SH=0 gapped valid with stray i_start mid-window
    arm(8'd3);
    samp(8, 8);
    tick();
    i_vld = 1'b0;
    i_start = 1'b1;
    i_len = 8'd1;
    tick();
    i_start = 1'b0;
    chk("t4_gap_vld", v0, 0);
    tick();
    samp(8, 8);
    tick();
    i_vld = 1'b0;
    chk("t4_mid_vld", v0, 0);
    chk("t4_mid_busy", b0, 1);
    tick();
    samp(8, 8);
    tick();
    i_vld = 1'b0;
    chk("t4_vld_early", v0, 0);
    tick();
    chk("t4_vld", v0, 1);
    chk("t4_qr", $signed(r0), 24);
    chk("t4_qi", $signed(q0), 24);
    chk("t4_ovf", f0, 0);

    // SH=0 back-to-back windows
    arm(8'd2);
    samp(1, 2);
    tick();
    samp(3, 4);
    tick();
    i_vld = 1'b0;
    i_start = 1'b1;
    i_len = 8'd1;
    tick();
    i_start = 1'b0;
    chk("t5_vld1", v0, 1);
    chk("t5_qr1", $signed(r0), 4);
    chk("t5_qi1", $signed(q0), 6);
    chk("t5_busy", b0, 1);
    samp(5, -5);
    tick();
    i_vld = 1'b0;
    chk("t5_vld_gap", v0, 0);
    tick();
    chk("t5_vld2", v0, 1);
    chk("t5_qr2", $signed(r0), 5);
    chk("t5_qi2", $signed(q0), -5);
    chk("t5_busy_end", b0, 0);

    // Asynchronous reset mid-window
    arm(8'd4);
    samp(100, 100);
    repeat (2) tick();
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_busy", b0, 0);
    chk("t6_qr", $signed(r0), 0);
    chk("t6_qi", $signed(q0), 0);
    chk("t6_vld", v0, 0);
    #2 i_rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_no_vld", v0, 0);
      chk("t6_no_busy", b0, 0);
    end
    i_vld = 1'b0;
    arm(8'd1);
    samp(7, -3);
    tick();
    i_vld = 1'b0;
    tick();
    chk("t6_vld", v0, 1);
    chk("t6_fresh_qr", $signed(r0), 7);
    chk("t6_fresh_qi", $signed(q0), -3);
    chk("t6_fresh_ovf", f0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
